// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter.
// Merges REQ_NUM valid/ready/last/data streams into one downstream stream.
// A grant is held for a whole packet (through the beat with last). The
// highest-priority channel (ptr) may send up to its weight in back-to-back
// packets before priority rotates to the next channel.
//
// Ports:
//   clk, rstn  - clock (rising edge), asynchronous active-low reset
//   valid_in   - per-channel valid            [REQ_NUM]
//   ready_in   - per-channel ready, one-hot or zero [REQ_NUM]
//   last_in    - per-channel end-of-packet    [REQ_NUM]
//   data_in    - payloads, channel i at [i*DATA_W +: DATA_W]
//   weight_in  - packet quotas, channel i at [i*WEIGHT_W +: WEIGHT_W]; 0 acts as 1
//   valid_out, ready_out, last_out, data_out - downstream stream
//   grant_id   - index of the selected channel
module wrr_packet_arbiter #(
  parameter int unsigned REQ_NUM  = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned ID_W     = $clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [REQ_NUM-1:0]           valid_in,
  output logic [REQ_NUM-1:0]           ready_in,
  input  logic [REQ_NUM-1:0]           last_in,
  input  logic [REQ_NUM*DATA_W-1:0]    data_in,
  input  logic [REQ_NUM*WEIGHT_W-1:0]  weight_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic                         last_out,
  output logic [DATA_W-1:0]            data_out,
  output logic [ID_W-1:0]              grant_id
);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_e;

  lock_e               locked_q, locked_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0]     sel;
  logic                found;
  logic [ID_W:0]       sum;
  logic [ID_W-1:0]     cand;
  logic                fire;
  logic [WEIGHT_W-1:0] eff_w;
  logic [WEIGHT_W-1:0] base;
  logic [WEIGHT_W:0]   nxt_cnt;

  // Channel selection. Reset is folded in combinationally so the outputs
  // fall to their idle values as soon as rstn drops, not at the next edge.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    if (!rstn) begin
      sel = '0;
    end else if (locked_q == ST_LOCKED) begin
      sel = lock_id_q;
    end else begin
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
        // ptr + k modulo REQ_NUM without a divider (sum < 2*REQ_NUM).
        sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(REQ_NUM)) sum = sum - (ID_W+1)'(REQ_NUM);
        cand = sum[ID_W-1:0];
        if (!found && valid_in[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (!rstn)                        valid_out = 1'b0;
    else if (locked_q == ST_LOCKED)   valid_out = valid_in[lock_id_q];
    else                              valid_out = |valid_in;
    last_out = last_in[sel];
    data_out = data_in[sel*DATA_W +: DATA_W];
    grant_id = sel;
    fire     = valid_out & ready_out;
    ready_in = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      ready_in[i] = (sel == ID_W'(i)) && ready_out && valid_out;
    end
  end

  // Quota bookkeeping. base restarts at 0 when a channel other than ptr
  // wins, which is how an idle ptr forfeits the rest of its turn.
  always_comb begin
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    eff_w     = weight_in[sel*WEIGHT_W +: WEIGHT_W];
    if (eff_w == '0) eff_w = WEIGHT_W'(1);
    base      = (sel == ptr_q) ? cnt_q : '0;
    nxt_cnt   = {1'b0, base} + (WEIGHT_W+1)'(1);
    if (fire) begin
      if (!last_out) begin
        locked_d  = ST_LOCKED;
        lock_id_d = sel;
      end else begin
        locked_d = ST_OPEN;
        if (nxt_cnt < {1'b0, eff_w}) begin
          ptr_d = sel;
          cnt_d = nxt_cnt[WEIGHT_W-1:0];
        end else begin
          ptr_d = (sel == ID_W'(REQ_NUM-1)) ? '0 : sel + ID_W'(1);
          cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      locked_q  <= ST_OPEN;
      lock_id_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
